// File: rtl/downsample_max.sv
// downsample_max: peak-hold decimator for the ADC front end.
// Tracks the signed maximum of every DS_FACTOR accepted samples (ena=1) and
// emits it with a one-cycle write strobe, suppressed while the downstream
// FIFO reports outbusy at window close.
// Optional build macro ABS_PEAK_EN: select by magnitude instead of signed
// value; the original signed sample is stored and output.
module downsample_max #(
  parameter int DATA_W    = 12,
  parameter int DS_FACTOR = 10,
  parameter int CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic signed [DATA_W-1:0] dataIn,
  input  logic                     outbusy,
  output logic signed [DATA_W-1:0] dsoutdata,
  output logic                     out_en
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DS_FACTOR - 1);

`ifdef ABS_PEAK_EN
  // Magnitude tracking: the first sample of a window is always loaded, so the
  // idle value of the running peak only needs to be a zero magnitude.
  localparam logic signed [DATA_W-1:0] PEAK_INIT = '0;

  // |x| in DATA_W+1 bits so the most negative code has the largest magnitude.
  function automatic logic [DATA_W:0] mag(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] ext;
    ext = {x[DATA_W-1], x};
    return ext[DATA_W] ? $unsigned(-ext) : $unsigned(ext);
  endfunction
`else
  localparam logic signed [DATA_W-1:0] PEAK_INIT = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] peak_q, peak_d;
  logic signed [DATA_W-1:0] dsoutdata_q, dsoutdata_d;
  logic                     out_en_q, out_en_d;
  logic signed [DATA_W-1:0] pick;

  // Winner between the running peak and the incoming sample; ties keep the peak.
  always_comb begin
`ifdef ABS_PEAK_EN
    pick = (cnt_q == '0 || mag(dataIn) > mag(peak_q)) ? dataIn : peak_q;
`else
    pick = (dataIn > peak_q) ? dataIn : peak_q;
`endif
  end

  // Window accounting: accumulate on accepted samples, publish on the last one.
  always_comb begin
    cnt_d       = cnt_q;
    peak_d      = peak_q;
    dsoutdata_d = dsoutdata_q;
    out_en_d    = 1'b0;
    if (ena) begin
      if (cnt_q == LAST_CNT) begin
        dsoutdata_d = pick;
        cnt_d       = '0;
        peak_d      = PEAK_INIT;
        out_en_d    = ~outbusy;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        peak_d = pick;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      peak_q      <= PEAK_INIT;
      dsoutdata_q <= '0;
      out_en_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      peak_q      <= peak_d;
      dsoutdata_q <= dsoutdata_d;
      out_en_q    <= out_en_d;
    end
  end

  assign dsoutdata = dsoutdata_q;
  assign out_en    = out_en_q;

endmodule

// File: tb/tb_downsample_max.sv
// Testbench for downsample_max: directed scenarios plus randomized traffic,
// all compared against a window-list reference model.
module tb_downsample_max;

  localparam int DW = 12;
  localparam int DS = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ena = 1'b0;
  logic                 outbusy = 1'b0;
  logic signed [DW-1:0] dataIn = '0;
  logic signed [DW-1:0] dsoutdata;
  logic                 out_en;

  int checks = 0;
  int errors = 0;

  // Reference model: list of accepted samples in the current window.
  int win[$];
  int exp_data = 0;
  logic exp_en = 1'b0;

  downsample_max #(.DATA_W(DW), .DS_FACTOR(DS), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .dataIn(dataIn),
    .outbusy(outbusy), .dsoutdata(dsoutdata), .out_en(out_en)
  );

  always #5 clk = ~clk;

  function automatic int absval(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Window result from the list of accepted samples.
  function automatic int window_result();
    int best;
    best = win[0];
    for (int i = 1; i < win.size(); i++) begin
`ifdef ABS_PEAK_EN
      if (absval(win[i]) > absval(best)) best = win[i];
`else
      if (win[i] > best) best = win[i];
`endif
    end
    return best;
  endfunction

  // Drive one cycle, advance the model; outputs are observed 1 time unit after the edge.
  task automatic step(input logic e, input int d, input logic b);
    ena = e;
    dataIn = DW'(d);
    outbusy = b;
    @(posedge clk);
    #1;
    exp_en = 1'b0;
    if (e) begin
      win.push_back(d);
      if (win.size() == DS) begin
        exp_data = window_result();
        exp_en = ~b;
        win.delete();
      end
    end
  endtask

  task automatic do_reset();
    ena = 1'b0;
    outbusy = 1'b0;
    rst = 1'b1;
    win.delete();
    exp_data = 0;
    exp_en = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_en !== 1'b0) begin
      errors++; $display("FAIL reset_out_en got %b exp 0", out_en);
    end
    checks++;
    if (dsoutdata !== 12'sd0) begin
      errors++; $display("FAIL reset_dsoutdata got %0d exp 0", dsoutdata);
    end
  endtask

  task automatic test_ramp();
    int pulses = 0;
    int vals[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i, 1'b0);
      checks++;
      if (out_en !== exp_en) begin
        errors++; $display("FAIL ramp_en cyc %0d got %b exp %b", i, out_en, exp_en);
      end
      if (out_en === 1'b1) begin
        pulses++;
        vals.push_back(int'(dsoutdata));
      end
    end
    step(1'b0, 0, 1'b0);
    if (out_en === 1'b1) pulses++;
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL ramp_pulses got %0d exp 2", pulses);
    end
    checks++;
    if (vals.size() != 2 || vals[0] != 9 || vals[1] != 19) begin
      errors++; $display("FAIL ramp_values got %p exp 9,19", vals);
    end
  endtask

  task automatic test_full_scale();
    int w2[10] = '{3, -7, 2047, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < DS; i++) step(1'b1, -2048, 1'b0);
    checks++;
    if (out_en !== 1'b1 || dsoutdata !== -12'sd2048) begin
      errors++; $display("FAIL full_neg got en=%b d=%0d exp en=1 d=-2048", out_en, dsoutdata);
    end
    for (int i = 0; i < DS; i++) step(1'b1, w2[i], 1'b0);
    checks++;
    if (out_en !== 1'b1 || dsoutdata !== 12'sd2047) begin
      errors++; $display("FAIL full_pos got en=%b d=%0d exp en=1 d=2047", out_en, dsoutdata);
    end
  endtask

  task automatic test_ena_gap();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step((i % 2) == 0, i + 1, 1'b0);
      checks++;
      if (out_en !== exp_en || dsoutdata !== DW'(exp_data)) begin
        errors++;
        $display("FAIL ena_gap cyc %0d got en=%b d=%0d exp en=%b d=%0d",
                 i, out_en, dsoutdata, exp_en, exp_data);
      end
      if (out_en === 1'b1) begin
        pulses++;
        checks++;
        if (i != 18 || dsoutdata !== 12'sd19) begin
          errors++; $display("FAIL ena_gap_pulse cyc %0d d=%0d exp cyc 18 d=19", i, dsoutdata);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL ena_gap_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_outbusy();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < DS; i++) begin
      step(1'b1, $urandom_range(0, 4095) - 2048, 1'b1);
      if (out_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL busy_drop got %0d pulses exp 0", pulses);
    end
    checks++;
    if (dsoutdata !== DW'(exp_data)) begin
      errors++; $display("FAIL busy_data got %0d exp %0d", dsoutdata, exp_data);
    end
    for (int i = 0; i < DS; i++) step(1'b1, (i == DS - 1) ? 100 : 5, (i == 3));
    checks++;
    if (out_en !== 1'b1 || dsoutdata !== 12'sd100) begin
      errors++; $display("FAIL busy_next got en=%b d=%0d exp en=1 d=100", out_en, dsoutdata);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 50, 1'b0);
    do_reset();
    checks++;
    if (out_en !== 1'b0 || dsoutdata !== 12'sd0) begin
      errors++; $display("FAIL rst_mid got en=%b d=%0d exp en=0 d=0", out_en, dsoutdata);
    end
    for (int i = 0; i < DS; i++) begin
      step(1'b1, 1, 1'b0);
      if (out_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || out_en !== 1'b1 || dsoutdata !== 12'sd1) begin
      errors++; $display("FAIL rst_mid_next got pulses=%0d d=%0d exp 1 pulse d=1", pulses, dsoutdata);
    end
  endtask

`ifdef ABS_PEAK_EN
  task automatic test_abs_peak();
    int w1[10] = '{-2048, 2047, 0, 0, 0, 0, 0, 0, 0, 0};
    int w2[10] = '{-3, 2, -1, 0, 0, 0, 0, 0, 0, 0};
    int w3[10] = '{5, -5, 1, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < DS; i++) step(1'b1, w1[i], 1'b0);
    checks++;
    if (out_en !== 1'b1 || dsoutdata !== -12'sd2048) begin
      errors++; $display("FAIL abs_full got d=%0d exp -2048", dsoutdata);
    end
    for (int i = 0; i < DS; i++) step(1'b1, w2[i], 1'b0);
    checks++;
    if (out_en !== 1'b1 || dsoutdata !== -12'sd3) begin
      errors++; $display("FAIL abs_small got d=%0d exp -3", dsoutdata);
    end
    for (int i = 0; i < DS; i++) step(1'b1, w3[i], 1'b0);
    checks++;
    if (out_en !== 1'b1 || dsoutdata !== 12'sd5) begin
      errors++; $display("FAIL abs_tie got d=%0d exp 5", dsoutdata);
    end
  endtask
`endif

  task automatic test_random();
    int d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: d = -2048;
        1: d = 2047;
        default: d = $urandom_range(0, 4095) - 2048;
      endcase
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0);
      checks++;
      if (out_en !== exp_en || dsoutdata !== DW'(exp_data)) begin
        errors++;
        $display("FAIL random cyc %0d got en=%b d=%0d exp en=%b d=%0d",
                 i, out_en, dsoutdata, exp_en, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_full_scale();
    test_ena_gap();
    test_outbusy();
    test_reset_mid();
`ifdef ABS_PEAK_EN
    test_abs_peak();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
